// File: rtl/irq_ctrl_if.sv
// CSR bus shared with the I2C slave: 5-bit address, 8-bit data, one-cycle write strobe.
interface irq_ctrl_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, csr_di, csr_we, input csr_do);
  modport slave  (input csr_a, csr_di, csr_we, output csr_do);
endinterface

// File: rtl/irq_ctrl.sv
// Maskable edge/level interrupt controller with W1C pending bits on the shared CSR bus.
// Optional per-channel debounce filter enabled by defining IRQ_CTRL_DEBOUNCE_EN.
module irq_ctrl #(
  parameter logic [4:0]  BASE_ADDR    = 5'h1c,
  parameter int unsigned NUM_INTS     = 8,
  parameter logic [7:0]  DFL_IE       = 8'h00,
  parameter logic [7:0]  DFL_MODE     = 8'h00,
  parameter logic [7:0]  DFL_POL      = 8'h00,
  parameter logic [2:0]  DEBOUNCE_CNT = 3'd3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  irq_ctrl_if.slave           csr,
  // raw sources; the original name `int` is a reserved word in SystemVerilog
  input  logic [NUM_INTS-1:0] ints,
  output logic                irq
);

  logic [NUM_INTS-1:0] ie, ip, mode, pol;
  logic [NUM_INTS-1:0] s1, s2, filt;
  logic [NUM_INTS-1:0] act_c, act_q, set, w1c;
  logic [4:0]          off;
  logic                hit;

  assign off = csr.csr_a - BASE_ADDR;
  assign hit = (off[4:2] == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ints;
      s2 <= s1;
    end
  end

`ifdef IRQ_CTRL_DEBOUNCE_EN
  logic [2:0] cnt [NUM_INTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int unsigned i = 0; i < NUM_INTS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_INTS; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (ce) begin
          if (cnt[i] + 3'd1 == DEBOUNCE_CNT) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 3'd1;
          end
        end
      end
    end
  end
`else
  logic                 ce_unused;
  localparam logic [2:0] debounce_cnt_unused = DEBOUNCE_CNT;
  assign ce_unused = ce;
  assign filt      = s2;
`endif

  // Edge detection compares the live act with its registered copy so IP sets on the same edge act is registered.
  assign act_c = filt ^ pol;
  assign set   = act_c & (mode | ~act_q);
  assign w1c   = (csr.csr_we && hit && off[1:0] == 2'd1) ? csr.csr_di[NUM_INTS-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie    <= DFL_IE[NUM_INTS-1:0];
      mode  <= DFL_MODE[NUM_INTS-1:0];
      pol   <= DFL_POL[NUM_INTS-1:0];
      ip    <= '0;
      act_q <= '0;
      irq   <= 1'b0;
    end else begin
      act_q <= act_c;
      ip    <= (ip & ~w1c) | set;
      irq   <= |(ip & ie);
      if (csr.csr_we && hit) begin
        case (off[1:0])
          2'd0:    ie   <= csr.csr_di[NUM_INTS-1:0];
          2'd2:    mode <= csr.csr_di[NUM_INTS-1:0];
          2'd3:    pol  <= csr.csr_di[NUM_INTS-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr.csr_do = '0;
    if (hit) begin
      case (off[1:0])
        2'd0:    csr.csr_do[NUM_INTS-1:0] = ie;
        2'd1:    csr.csr_do[NUM_INTS-1:0] = ip;
        2'd2:    csr.csr_do[NUM_INTS-1:0] = mode;
        default: csr.csr_do[NUM_INTS-1:0] = pol;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; the debounce section is selected by IRQ_CTRL_DEBOUNCE_EN.
module tb_irq_ctrl;
  localparam logic [4:0] A_IE   = 5'h1c;
  localparam logic [4:0] A_IP   = 5'h1d;
  localparam logic [4:0] A_MODE = 5'h1e;
  localparam logic [4:0] A_POL  = 5'h1f;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] ints = '0;
  logic [3:0] ints4 = '0;
  logic       irq, irq4;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rdv;

  irq_ctrl_if bus ();
  irq_ctrl_if bus4 ();

  irq_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .csr(bus), .ints(ints), .irq(irq)
  );

  irq_ctrl #(.NUM_INTS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .csr(bus4), .ints(ints4), .irq(irq4)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (7) @(posedge clk);
      #1 ce = 1'b1;
      @(posedge clk);
      #1 ce = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    bus.csr_a  = a;
    bus.csr_di = d;
    bus.csr_we = 1'b1;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    bus.csr_a = a;
    #1;
    rdv = bus.csr_do;
    check(tag, rdv, exp);
  endtask

  initial begin
    bus.csr_a = '0; bus.csr_di = '0; bus.csr_we = 1'b0;
    bus4.csr_a = '0; bus4.csr_di = '0; bus4.csr_we = 1'b0;
    tick(3);
    chk_reg("rst_ie", A_IE, 8'h00);
    chk_reg("rst_ip", A_IP, 8'h00);
    chk_reg("rst_mode", A_MODE, 8'h00);
    chk_reg("rst_pol", A_POL, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    tick(2);

`ifdef IRQ_CTRL_DEBOUNCE_EN
    wr(A_IE, 8'h10);
    ints[4] = 1'b1;
    tick(16);
    ints[4] = 1'b0;
    tick(40);
    chk_reg("db_short_pulse", A_IP, 8'h00);
    ints[4] = 1'b1;
    tick(40);
    chk_reg("db_long_pulse", A_IP, 8'h10);
    check("db_long_irq", {7'd0, irq}, 8'h01);
    ints[4] = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk_reg("db_rst_ip", A_IP, 8'h00);
    check("db_rst_irq", {7'd0, irq}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
`else
    // latency: E1..E3 sets IP, irq after E4
    wr(A_IE, 8'h01);
    ints[0] = 1'b1;
    tick(2);
    chk_reg("lat_ip_e2", A_IP, 8'h00);
    tick();
    chk_reg("lat_ip_e3", A_IP, 8'h01);
    check("lat_irq_e3", {7'd0, irq}, 8'h00);
    tick();
    check("lat_irq_e4", {7'd0, irq}, 8'h01);
    wr(A_IP, 8'h01);
    chk_reg("w1c0_ip", A_IP, 8'h00);
    check("w1c0_irq_w", {7'd0, irq}, 8'h01);
    tick();
    check("w1c0_irq_w1", {7'd0, irq}, 8'h00);
    ints[0] = 1'b0;

    // active-low edge on channel 1
    wr(A_IE, 8'h02);
    wr(A_POL, 8'h02);
    ints[1] = 1'b1;
    tick(6);
    wr(A_IP, 8'h02);
    chk_reg("pol_clr_setup", A_IP, 8'h00);
    ints[1] = 1'b0;
    tick(3);
    chk_reg("fall_sets_ip", A_IP, 8'h02);
    tick();
    check("fall_irq", {7'd0, irq}, 8'h01);
    tick(5);
    wr(A_IP, 8'h02);
    chk_reg("fall_w1c_ip", A_IP, 8'h00);
    check("fall_w1c_irq_w", {7'd0, irq}, 8'h01);
    tick();
    check("fall_w1c_irq_w1", {7'd0, irq}, 8'h00);
    tick(5);
    chk_reg("hold_low_no_reset", A_IP, 8'h00);

    // level mode on channel 2
    wr(A_MODE, 8'h04);
    ints[2] = 1'b1;
    tick(4);
    chk_reg("lvl_set", A_IP, 8'h04);
    wr(A_IP, 8'h04);
    chk_reg("lvl_w1c_active", A_IP, 8'h04);
    ints[2] = 1'b0;
    tick(3);
    wr(A_IP, 8'h04);
    chk_reg("lvl_w1c_idle", A_IP, 8'h00);

    // masking on channel 3
    wr(A_IE, 8'h00);
    ints[3] = 1'b1;
    tick(4);
    chk_reg("mask_ip", A_IP, 8'h08);
    check("mask_irq", {7'd0, irq}, 8'h00);
    wr(A_IE, 8'h08);
    check("unmask_irq_w", {7'd0, irq}, 8'h00);
    tick();
    check("unmask_irq_w1", {7'd0, irq}, 8'h01);

    // W1C collides with a fresh edge: set wins
    ints[0] = 1'b1;
    tick(4);
    chk_reg("ip0_pre", A_IP, 8'h09);
    ints[0] = 1'b0;
    tick(4);
    ints[0] = 1'b1;
    tick(2);
    wr(A_IP, 8'h01);
    chk_reg("set_beats_w1c", A_IP, 8'h09);
    wr(A_IP, 8'h01);
    chk_reg("w1c_after", A_IP, 8'h08);

    chk_reg("unmapped_base4", 5'h00, 8'h00);
    chk_reg("unmapped_below", 5'h1b, 8'h00);

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    chk_reg("async_rst_ip", A_IP, 8'h00);
    chk_reg("async_rst_ie", A_IE, 8'h00);
    check("async_rst_irq", {7'd0, irq}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(2);
`endif

    // NUM_INTS=4: upper bits ignore writes and read 0
    bus4.csr_a  = A_IE;
    bus4.csr_di = 8'hff;
    bus4.csr_we = 1'b1;
    tick();
    bus4.csr_we = 1'b0;
    #1;
    check("n4_ie_ff", bus4.csr_do, 8'h0f);
    bus4.csr_a  = A_MODE;
    bus4.csr_di = 8'ha5;
    bus4.csr_we = 1'b1;
    tick();
    bus4.csr_we = 1'b0;
    #1;
    check("n4_mode_a5", bus4.csr_do, 8'h05);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
